// File: rtl/spi_wrapper.sv
// SPI slave front-end with a 256x8 single-port RAM, all logic on one system clock.
// 10-bit frames: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data (byte returned on MISO).
module spi_wrapper #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic MOSI,
   input  logic SS_n,
   output logic MISO
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CHK_CMD   = 3'd1;
   localparam logic [2:0] WRITE     = 3'd2;
   localparam logic [2:0] READ_ADD  = 3'd3;
   localparam logic [2:0] READ_DATA = 3'd4;

   logic [2:0]           state;
   logic [3:0]           bit_cnt;
   logic [9:0]           rx_data;
   logic                 rx_valid;
   logic [2:0]           rx_kind;
   logic                 tx_valid;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;
   logic                 rd_flag;
   logic [7:0]           mem [MEM_DEPTH];
   logic [7:0]           dout;
   logic [7:0]           tx_sh;
   logic [2:0]           tx_left;
   logic                 tx_active;

   // Frame capture: the state that received the word is remembered with rx_valid
   // so the decode still knows the command kind after SS_n has been released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         rx_data  <= 10'd0;
         rx_valid <= 1'b0;
         rx_kind  <= IDLE;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
         end else begin
            case (state)
               IDLE: state <= CHK_CMD;
               CHK_CMD: begin
                  rx_data <= {rx_data[8:0], MOSI};
                  bit_cnt <= 4'd1;
                  state   <= (!MOSI) ? WRITE : (rd_flag ? READ_DATA : READ_ADD);
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (bit_cnt != 4'd10) begin
                     rx_data <= {rx_data[8:0], MOSI};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd9) begin
                        rx_valid <= 1'b1;
                        rx_kind  <= state;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Command decode and MISO serializer; an SS_n release silences MISO but keeps the flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr   <= '0;
         rd_addr   <= '0;
         rd_flag   <= 1'b0;
         tx_valid  <= 1'b0;
         MISO      <= 1'b0;
         tx_active <= 1'b0;
         tx_left   <= 3'd0;
      end else begin
         tx_valid <= 1'b0;
         if (rx_valid) begin
            case (rx_kind)
               WRITE:     if (rx_data[9:8] == 2'b00) wr_addr <= rx_data[ADDR_SIZE-1:0];
               READ_ADD: begin
                  rd_addr <= rx_data[ADDR_SIZE-1:0];
                  rd_flag <= 1'b1;
               end
               READ_DATA: tx_valid <= 1'b1;
               default: ;
            endcase
         end
         if (SS_n) begin
            MISO      <= 1'b0;
            tx_active <= 1'b0;
         end else if (tx_valid) begin
            MISO      <= dout[7];
            tx_active <= 1'b1;
            tx_left   <= 3'd7;
         end else if (tx_active) begin
            if (tx_left != 3'd0) begin
               MISO    <= tx_sh[7];
               tx_left <= tx_left - 3'd1;
            end else begin
               MISO      <= 1'b0;
               tx_active <= 1'b0;
               rd_flag   <= 1'b0;
            end
         end
      end
   end

   // RAM and read datapath carry no reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (rx_valid && rx_kind == WRITE && rx_data[9:8] == 2'b01)
         mem[wr_addr] <= rx_data[7:0];
      if (rx_valid && rx_kind == READ_DATA)
         dout <= mem[rd_addr];
      if (tx_valid)
         tx_sh <= {dout[6:0], 1'b0};
      else if (tx_active)
         tx_sh <= {tx_sh[6:0], 1'b0};
   end

endmodule

// File: tb/tb_spi_wrapper.sv
// Directed bench for spi_wrapper: table of frames with expected read bytes,
// plus hand sequences for read-without-address, aborted write and mid-shift reset.
module tb_spi_wrapper;

   logic clk;
   logic rst_n;
   logic MOSI;
   logic SS_n;
   logic MISO;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [9:0] frame;
      bit         is_read;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [14];

   spi_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .MOSI (MOSI),
      .SS_n (SS_n),
      .MISO (MISO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Sends nbits of w (MSB first); win[j] holds MISO j cycles after the last bit.
   task automatic send_frame(input logic [9:0] w, input int nbits, input int hold,
                             output logic [14:0] win);
      win = '0;
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         MOSI = w[9-i];
      end
      for (int j = 1; j <= hold; j++) begin
         @(negedge clk);
         win[j] = MISO;
      end
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
   endtask

   // Expected bytes all begin with 1, so the first 1 in the window marks the start.
   task automatic check_read(input string name, input logic [14:0] win, input logic [7:0] exp);
      int start;
      int tail;
      logic [7:0] b;
      start = 0;
      tail  = 0;
      b     = '0;
      for (int j = 14; j >= 1; j--) if (win[j]) start = j;
      check({name, "_latency"}, int'(start >= 1 && start <= 4), 1);
      if (start >= 1 && start + 7 <= 14)
         for (int k = 0; k < 8; k++) b[7-k] = win[start+k];
      check({name, "_byte"}, int'(b), int'(exp));
      if (start >= 1)
         for (int j = start + 8; j <= 14; j++) tail |= int'(win[j]);
      check({name, "_idle_after"}, tail, 0);
   endtask

   initial begin
      logic [14:0] win;
      bit found;
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      SS_n  = 1'b1;
      MOSI  = 1'b0;

      vecs[0]  = '{10'h0FF, 1'b0, 8'h00};
      vecs[1]  = '{10'h1B1, 1'b0, 8'h00};
      vecs[2]  = '{10'h2FF, 1'b0, 8'h00};
      vecs[3]  = '{10'h3BC, 1'b1, 8'hB1};
      vecs[4]  = '{10'h0FE, 1'b0, 8'h00};
      vecs[5]  = '{10'h1AA, 1'b0, 8'h00};
      vecs[6]  = '{10'h2FE, 1'b0, 8'h00};
      vecs[7]  = '{10'h3AE, 1'b1, 8'hAA};
      vecs[8]  = '{10'h0FD, 1'b0, 8'h00};
      vecs[9]  = '{10'h1BB, 1'b0, 8'h00};
      vecs[10] = '{10'h2FD, 1'b0, 8'h00};
      vecs[11] = '{10'h3AE, 1'b1, 8'hBB};
      vecs[12] = '{10'h2FE, 1'b0, 8'h00};
      vecs[13] = '{10'h3AE, 1'b1, 8'hAA};

      repeat (3) @(negedge clk);
      check("reset_miso", int'(MISO), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 14; v++) begin
         send_frame(vecs[v].frame, 10, 14, win);
         if (vecs[v].is_read)
            check_read($sformatf("vec%0d", v), win, vecs[v].exp);
         else
            check($sformatf("vec%0d_miso_quiet", v), int'(win), 0);
      end

      // Read-data frame with no pending address: acts as read-address of 0xFE.
      send_frame(10'h3FE, 10, 14, win);
      check("rd_noflag_miso_quiet", int'(win), 0);
      send_frame(10'h300, 10, 14, win);
      check_read("rd_after_noflag", win, 8'hAA);

      // Write-data frame aborted after 5 bits must leave mem[0xFD] alone.
      send_frame(10'h0FD, 10, 3, win);
      send_frame(10'h1CC, 5, 0, win);
      send_frame(10'h2FD, 10, 3, win);
      send_frame(10'h300, 10, 14, win);
      check_read("abort_keeps", win, 8'hBB);

      // Reset while the byte is on MISO.
      send_frame(10'h2FE, 10, 3, win);
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         MOSI = 1'b1;
      end
      found = 1'b0;
      for (int j = 0; j < 8 && !found; j++) begin
         @(negedge clk);
         if (MISO) found = 1'b1;
      end
      check("rst_shift_started", int'(found), 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_miso_immediate", int'(MISO), 0);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_frame(10'h3FD, 10, 14, win);
      check("rst_flag_cleared", int'(win), 0);
      send_frame(10'h300, 10, 14, win);
      check_read("rst_ram_fd", win, 8'hBB);
      send_frame(10'h2FE, 10, 3, win);
      send_frame(10'h300, 10, 14, win);
      check_read("rst_ram_fe", win, 8'hAA);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
